io_handshake: RTL and testbench
===============================

# io_handshake

Operator I/O controller that drives the `Enter` handshake the program counter stalls on during IN/OUT instructions. While the decoded instruction is IN or OUT, it synchronizes and debounces the physical push button and toggles `Enter` once per clean press. On the same press it captures the switch value for IN, or latches the register value onto the display for OUT. Sits between the board pins and the datapath/PC.

## Interface
- `DATA_WIDTH`, 32, datapath word width
- `SW_WIDTH`, 16, number of board switches (`SW_WIDTH <= DATA_WIDTH`)
- `DEBOUNCE_CYCLES`, 50000, consecutive stable synchronized cycles required to accept a level change (≥2)
- `clk`  in  1  system clock; all state on rising edge
- `reset`  in  1  synchronous, active-high; one clock; no asynchronous reset anywhere
- `button`  in  1  raw push button, active-high, asynchronous to `clk`, bouncy
- `switches`  in  SW_WIDTH  raw switch levels, asynchronous
- `Input`  in  1  current instruction is IN
- `Output`  in  1  current instruction is OUT
- `out_data`  in  DATA_WIDTH  register value to display on OUT
- `Enter`  out  1  handshake level to PC; toggles once per accepted press
- `in_data`  out  DATA_WIDTH  captured switches, zero-extended, held until next capture
- `in_valid`  out  1  one-cycle pulse in the cycle after capture
- `display`  out  DATA_WIDTH  held display value
- `waiting`  out  1  high while in WAIT_PRESS (drives "press Enter" LED)

## Operation
- Synchronizer: `button` and `switches` each pass through 2 flip-flops before any use.
- Debouncer: level register `db` (reset 0) plus counter sized for DEBOUNCE_CYCLES. When the synchronized button differs from `db`, the counter increments; otherwise it clears to 0. When the counter would reach DEBOUNCE_CYCLES, `db` takes the new level and the counter clears. A glitch shorter than DEBOUNCE_CYCLES never changes `db`.
- `press` = `db` rose on the previous edge (registered `db` vs prior value); single-cycle.
- FSM states IDLE, WAIT_PRESS, WAIT_RELEASE:
  - IDLE: if `Input | Output` → WAIT_PRESS. Presses in IDLE are ignored.
  - WAIT_PRESS: if `Input | Output` deasserted → IDLE, no toggle. Else on `press`: `Enter <= ~Enter`. If `Input`, `in_data <= {zero, switches_sync}` and `in_valid` pulses next cycle. If `Output`, `display <= out_data`. If both are high, both actions occur. → WAIT_RELEASE.
  - WAIT_RELEASE: when `db == 0` → IDLE. This guarantees one press advances exactly one I/O instruction, even when consecutive instructions are IN/OUT.
- A button already held (`db == 1`) on entry to WAIT_PRESS does not count; a fresh rise is required.
- `Enter` is a level, not a pulse; the PC detects change against its own copy, which also resets to 0.

## Timing
- Reset values: `Enter`=0, `in_data`=0, `in_valid`=0, `display`=0, `waiting`=0, `db`=0, counter=0, state IDLE, synchronizer flops 0.
- Reset mid-operation (any state) returns to IDLE on that edge, with outputs at their reset values. `Enter` returns to 0 in step with the PC's reset.
- Latency: raw `button` rising and staying stable → `Enter` toggle after exactly 2 + DEBOUNCE_CYCLES + 1 edges, given WAIT_PRESS was already active.
- `in_data`, `display` and `Enter` update on the same edge; `in_valid` is high for the following cycle only.
- `waiting` is registered; it goes high one edge after `Input | Output` rises in IDLE.
- Counter must not overflow; it saturates logic at DEBOUNCE_CYCLES.

## Test plan
- Reset: assert `reset` 1 cycle with `button`=1, `Input`=1 → all outputs 0, state IDLE, no `Enter` toggle until a release is followed by a fresh press.
- IN (DEBOUNCE_CYCLES=4): `Input`=1, `switches`=16'hA5C3, clean press → `Enter` 0→1 exactly 7 edges after button rise, `in_data`=32'h0000A5C3, `in_valid` single pulse, `display` unchanged.
- OUT: `Output`=1, `out_data`=32'hDEADBEEF, press → `display`=32'hDEADBEEF, `Enter` toggles, `in_valid` stays 0.
- Bounce: 3-cycle pulses separated by 2-cycle gaps, then stable high → exactly one toggle; a lone 3-cycle glitch → no toggle.
- Held button across back-to-back IN instructions: `Enter` toggles once; second toggle only after release ≥4 cycles and a new press.
- Reset while in WAIT_RELEASE with `Enter`=1 → `Enter`=0 on next edge, state IDLE.

Source files
------------

// File: rtl/io_handshake_if.sv
// Board/datapath-facing signal bundle for the operator I/O controller.
// Handshake: Enter is a level the PC compares against its own copy; each
// accepted press flips it once, and in_valid marks the cycle after an IN capture.
interface io_handshake_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SW_WIDTH   = 16
);
  logic                  button;
  logic [SW_WIDTH-1:0]   switches;
  logic                  Input;
  logic                  Output;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  Enter;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] display;
  logic                  waiting;

  modport slave (
    input  button, switches, Input, Output, out_data,
    output Enter, in_data, in_valid, display, waiting
  );

  modport master (
    output button, switches, Input, Output, out_data,
    input  Enter, in_data, in_valid, display, waiting
  );
endinterface

// File: rtl/io_handshake.sv
// Operator I/O controller: synchronizes and debounces the push button and
// advances exactly one IN/OUT instruction per clean press via the Enter level.
module io_handshake #(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  io_handshake_if.slave    io,
  output logic [1:0]       state_dbg
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t state, state_n;

  logic                  btn_s1, btn_s2;
  logic [SW_WIDTH-1:0]   sw_s1, sw_s2;
  logic                  db, db_q;
  logic [CNT_W-1:0]      cnt;
  logic                  press;
  logic                  capture;
  logic                  io_active;

  logic                  enter_q;
  logic [DATA_WIDTH-1:0] in_data_q;
  logic                  in_valid_q;
  logic [DATA_WIDTH-1:0] display_q;
  logic                  waiting_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= io.button;
      btn_s2 <= btn_s1;
      sw_s1  <= io.switches;
      sw_s2  <= sw_s1;
    end
  end

  // Any sample agreeing with db restarts the run, so short glitches never land.
  always_ff @(posedge clk) begin
    if (reset) begin
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      db_q <= db;
      if (btn_s2 != db) begin
        if (cnt == CNT_LAST) begin
          db  <= btn_s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press     = db & ~db_q;
  assign io_active = io.Input | io.Output;

  always_comb begin
    state_n = state;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (io_active) state_n = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!io_active) begin
          state_n = IDLE;
        end else if (press) begin
          capture = 1'b1;
          state_n = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!db) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      enter_q    <= 1'b0;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      display_q  <= '0;
      waiting_q  <= 1'b0;
    end else begin
      state      <= state_n;
      waiting_q  <= (state_n == WAIT_PRESS);
      in_valid_q <= capture & io.Input;
      if (capture) begin
        enter_q <= ~enter_q;
        if (io.Input)  in_data_q <= DATA_WIDTH'(sw_s2);
        if (io.Output) display_q <= io.out_data;
      end
    end
  end

  assign io.Enter    = enter_q;
  assign io.in_data  = in_data_q;
  assign io.in_valid = in_valid_q;
  assign io.display  = display_q;
  assign io.waiting  = waiting_q;
  assign state_dbg   = state;
endmodule

// File: tb/tb_io_handshake.sv
// Directed and randomized bench for io_handshake with a cycle-level
// behavioural model of press acceptance, capture and release.
module tb_io_handshake;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  io_handshake_if #(.DATA_WIDTH(32), .SW_WIDTH(16)) hs ();

  io_handshake #(.DATA_WIDTH(32), .SW_WIDTH(16), .DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .io        (hs),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Button as seen by logic lags the pin by two edges; a level change is
  // accepted after D consecutive disagreeing samples.
  logic [1:0]  m_bpipe;
  logic [15:0] m_swp1, m_swp2;
  bit          m_hist[$];
  bit          m_db, m_db_prev, m_press, m_seen;
  bit          m_armed, m_need_release;
  logic        exp_enter, exp_in_valid, exp_waiting;
  logic [31:0] exp_in_data, exp_display;
  logic [15:0] m_sw_seen;

  always @(posedge clk) begin
    m_press   = m_db & ~m_db_prev;
    m_seen    = m_bpipe[1];
    m_sw_seen = m_swp2;
    if (reset) begin
      m_bpipe = '0; m_swp1 = '0; m_swp2 = '0;
      m_hist.delete();
      m_db = 0; m_db_prev = 0; m_armed = 0; m_need_release = 0;
      exp_enter = 0; exp_in_valid = 0; exp_waiting = 0;
      exp_in_data = '0; exp_display = '0;
    end else begin
      exp_in_valid = 0;
      if (m_need_release) begin
        if (!m_db) m_need_release = 0;
      end else if (m_armed) begin
        if (!(hs.Input | hs.Output)) begin
          m_armed = 0;
        end else if (m_press) begin
          exp_enter = ~exp_enter;
          if (hs.Input) begin
            exp_in_data  = {16'h0000, m_sw_seen};
            exp_in_valid = 1;
          end
          if (hs.Output) exp_display = hs.out_data;
          m_armed = 0;
          m_need_release = 1;
        end
      end else if (hs.Input | hs.Output) begin
        m_armed = 1;
      end
      exp_waiting = m_armed;
      m_db_prev = m_db;
      if (m_seen == m_db) m_hist.delete();
      else m_hist.push_back(m_seen);
      if (m_hist.size() == D) begin
        m_db = ~m_db;
        m_hist.delete();
      end
      m_bpipe = {m_bpipe[0], hs.button};
      m_swp2  = m_swp1;
      m_swp1  = hs.switches;
    end
  end

  // ---------------- checking ----------------
  int   checks = 0;
  int   errors = 0;
  int   toggles = 0;
  int   iv_seen = 0;
  logic enter_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("enter",    {31'd0, hs.Enter},    {31'd0, exp_enter});
      chk("in_data",  hs.in_data,           exp_in_data);
      chk("in_valid", {31'd0, hs.in_valid}, {31'd0, exp_in_valid});
      chk("display",  hs.display,           exp_display);
      chk("waiting",  {31'd0, hs.waiting},  {31'd0, exp_waiting});
      chk("state",    {30'd0, state_dbg},
          {30'd0, (m_need_release ? 2'd2 : (m_armed ? 2'd1 : 2'd0))});
      if (hs.Enter !== enter_prev) toggles++;
      enter_prev = hs.Enter;
      if (hs.in_valid === 1'b1) iv_seen++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int lat;
    logic e0;

    reset = 1'b1;
    hs.button = 1'b1; hs.switches = '0; hs.Input = 1'b1; hs.Output = 1'b0;
    hs.out_data = '0;

    // reset with button held and IN pending
    step(1);
    chk("rst_enter",    {31'd0, hs.Enter},    32'd0);
    chk("rst_in_data",  hs.in_data,           32'd0);
    chk("rst_display",  hs.display,           32'd0);
    chk("rst_waiting",  {31'd0, hs.waiting},  32'd0);
    chk("rst_state",    {30'd0, state_dbg},   32'd0);
    reset = 1'b0;
    step(1);
    hs.button = 1'b0;
    step(8);
    chk("rst_no_toggle", toggles, 32'd0);

    // IN: latency, capture, single in_valid pulse
    hs.switches = 16'hA5C3;
    step(2);
    iv_seen = 0;
    e0 = hs.Enter;
    lat = 0;
    hs.button = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step(1);
      if (hs.Enter !== e0) begin
        lat = n;
        break;
      end
    end
    chk("in_latency", lat, 32'd7);
    chk("in_enter",   {31'd0, hs.Enter}, 32'd1);
    chk("in_data_val", hs.in_data, 32'h0000A5C3);
    step(4);
    chk("in_valid_once", iv_seen, 32'd1);
    chk("in_display_hold", hs.display, 32'd0);
    hs.button = 1'b0; hs.Input = 1'b0;
    step(10);

    // OUT
    hs.Output = 1'b1; hs.out_data = 32'hDEADBEEF;
    iv_seen = 0;
    step(2);
    hs.button = 1'b1;
    step(10);
    chk("out_display", hs.display, 32'hDEADBEEF);
    chk("out_enter",   {31'd0, hs.Enter}, 32'd0);
    chk("out_no_iv",   iv_seen, 32'd0);
    hs.button = 1'b0;
    step(8);
    hs.Output = 1'b0;
    step(2);

    // Bounce then stable high: one toggle
    hs.Input = 1'b1;
    step(2);
    base = toggles;
    repeat (3) begin
      hs.button = 1'b1; step(3);
      hs.button = 1'b0; step(2);
    end
    hs.button = 1'b1;
    step(10);
    chk("bounce_one_toggle", toggles - base, 32'd1);
    hs.button = 1'b0;
    step(10);

    // Lone short glitch: no toggle
    base = toggles;
    hs.button = 1'b1; step(3);
    hs.button = 1'b0; step(10);
    chk("glitch_no_toggle", toggles - base, 32'd0);

    // Held button across back-to-back IN instructions
    base = toggles;
    hs.button = 1'b1;
    step(12);
    hs.Input = 1'b0; step(1);
    hs.Input = 1'b1; step(12);
    chk("held_one_toggle", toggles - base, 32'd1);
    hs.button = 1'b0; step(6);
    hs.button = 1'b1; step(12);
    chk("held_second_toggle", toggles - base, 32'd2);
    hs.button = 1'b0;
    step(8);

    // Reset while waiting for release with Enter high
    reset = 1'b1; step(1);
    reset = 1'b0; hs.Input = 1'b0; step(8);
    hs.Input = 1'b1; step(2);
    hs.button = 1'b1; step(10);
    chk("wr_enter_high", {31'd0, hs.Enter}, 32'd1);
    chk("wr_state",      {30'd0, state_dbg}, 32'd2);
    reset = 1'b1; step(1);
    chk("wr_rst_enter", {31'd0, hs.Enter}, 32'd0);
    chk("wr_rst_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b0; hs.button = 1'b0; hs.Input = 1'b0;
    step(8);

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      hs.Input    = 1'($urandom_range(0, 1));
      hs.Output   = 1'($urandom_range(0, 1));
      hs.switches = 16'($urandom);
      hs.out_data = $urandom;
      hs.button   = 1'b1;
      step($urandom_range(1, 10));
      if ($urandom_range(0, 3) == 0) hs.Input = ~hs.Input;
      hs.button   = 1'b0;
      step($urandom_range(1, 10));
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1; step(1); reset = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
